// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction memory write port and
// load status for the imem_loader. The loader takes the slave side; the
// host/debug link (or a testbench) takes the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 32
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              core_hold;
  logic              done;
  logic              err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, core_hold, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, core_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream (word count byte,
// then 4 bytes per word, MSB first) and writes the assembled 32-bit words
// into the instruction memory from address 0 while holding the core in
// reset. Pulses done at the end of every load; err reports the last load.
// Optional feature macro: IMEM_LOADER_CSUM_EN adds a trailing modulo-256
// checksum byte over all data bytes; a mismatch sets err.
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam int WIDTH = 32;
  localparam int CW    = ADDR_W + 1;
  localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
  localparam logic [CW-1:0] ONE_W   = CW'(1);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CSUM,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_DONE
  } state_t;
`endif

  state_t            state;
  logic [CW-1:0]     word_cnt;
  logic [CW-1:0]     n_words;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_reg;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WIDTH-1:0]  wr_data_q;
  logic              err_q;
  logic              byte_ready;
  logic              accept;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  // The loader is ready for stream bytes in every state that consumes one.
  always_comb begin
    byte_ready = 1'b0;
    case (state)
      S_LEN:  byte_ready = 1'b1;
      S_LOAD: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: byte_ready = 1'b1;
`endif
      default: byte_ready = 1'b0;
    endcase
  end

  assign accept = bus.byte_valid && byte_ready;

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.core_hold  = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = err_q;

  // Load sequencer: parses the count byte, assembles words and issues writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      n_words   <= '0;
      byte_cnt  <= '0;
      asm_reg   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_LEN;
            err_q    <= 1'b0;
            word_cnt <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q   <= '0;
`endif
          end
        end

        S_LEN: begin
          if (accept) begin
            if (bus.byte_in == 8'd0) begin
              state <= S_DONE;
            end else if (bus.byte_in > DEPTH_B) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              n_words <= bus.byte_in[CW-1:0];
              state   <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            asm_reg <= {asm_reg[15:0], bus.byte_in};
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= csum_q + bus.byte_in;
`endif
            if (byte_cnt == 2'd3) begin
              wr_data_q <= {asm_reg, bus.byte_in};
              wr_addr_q <= word_cnt[ADDR_W-1:0];
              wr_en_q   <= 1'b1;
              word_cnt  <= word_cnt + ONE_W;
              byte_cnt  <= 2'd0;
              if ((word_cnt + ONE_W) == n_words) begin
`ifdef IMEM_LOADER_CSUM_EN
                state <= S_CSUM;
`else
                state <= S_DONE;
`endif
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (bus.byte_in != csum_q) begin
              err_q <= 1'b1;
            end
            state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected memory writes
// are queued as image bytes are driven and popped as wr_en strobes appear.
// Build with IMEM_LOADER_CSUM_EN defined to also exercise the checksum.
module tb_imem_loader;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_item_t;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_W(4), .WIDTH(32)) bus ();

  imem_loader #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wr_item_t    sb[$];
  int          checks;
  int          errors;
  int          done_seen;
  int          exp_done;
  logic [31:0] img [0:1];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wr", 32'd1, 32'd0);
      end else begin
        wr_item_t it;
        it = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(it.addr));
        checkOutput("wr_data", bus.wr_data, it.data);
      end
    end
    if (!rst && bus.done === 1'b1) done_seen++;
  end

  // Presents one byte (optionally after an idle cycle) and waits for it to transfer.
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic doStart();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    checkOutput("core_hold_after_start", 32'(bus.core_hold), 32'd1);
    checkOutput("err_cleared", 32'(bus.err), 32'd0);
  endtask

  task automatic waitDone(output bit wr_at_done);
    bit found;
    found = 1'b0;
    wr_at_done = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1'b1;
        wr_at_done = bus.wr_en;
      end
    end
    if (!found) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finishLoad(input logic exp_err);
    checkOutput("err_at_done", 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
    checkOutput("done_single", 32'(bus.done), 32'd0);
    checkOutput("err_held", 32'(bus.err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic runImage(input bit gaps, input bit mid_start,
                          input bit with_csum, input logic [7:0] csum,
                          input logic exp_err);
    bit wr_at;
    logic [31:0] w;
    doStart();
    exp_done++;
    applyStimulus(8'h02, gaps);
    for (int i = 0; i < 2; i++) begin
      w = img[i];
      sb.push_back('{addr: 4'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        if (mid_start && i == 1 && b == 0) bus.start = 1'b1;
        applyStimulus(w[31 - 8*b -: 8], gaps);
        bus.start = 1'b0;
      end
    end
    if (with_csum) applyStimulus(csum, gaps);
    waitDone(wr_at);
`ifndef IMEM_LOADER_CSUM_EN
    checkOutput("done_with_last_wr", 32'(wr_at), 32'd1);
`endif
    finishLoad(exp_err);
  endtask

  // Global safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    bit wr_at;
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    exp_done  = 0;
    img[0] = 32'h0400_0000;
    img[1] = 32'h0020_0001;

    // Reset with random inputs.
    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.start      = 1'($urandom_range(0, 1));
      bus.byte_in    = 8'($urandom_range(0, 255));
      bus.byte_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_core_hold", 32'(bus.core_hold), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] two-word image, continuous stream");
`ifdef IMEM_LOADER_CSUM_EN
    runImage(1'b0, 1'b0, 1'b1, 8'h25, 1'b0);
`else
    runImage(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

    $display("[TB] two-word image, gapped stream with stray start");
`ifdef IMEM_LOADER_CSUM_EN
    runImage(1'b1, 1'b1, 1'b1, 8'h25, 1'b0);
`else
    runImage(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
`endif

    $display("[TB] zero-length image");
    doStart();
    exp_done++;
    applyStimulus(8'h00, 1'b0);
    waitDone(wr_at);
    checkOutput("n0_no_wr", 32'(wr_at), 32'd0);
    finishLoad(1'b0);

    $display("[TB] oversize image N=17");
    doStart();
    exp_done++;
    applyStimulus(8'h11, 1'b0);
    waitDone(wr_at);
    checkOutput("n17_no_wr", 32'(wr_at), 32'd0);
    finishLoad(1'b1);
    bus.byte_in    = 8'h04;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("n17_ready_low", 32'(bus.byte_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;

    $display("[TB] reset in the middle of a load");
    doStart();
    applyStimulus(8'h02, 1'b0);
    sb.push_back('{addr: 4'd0, data: 32'h0400_0000});
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h20, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("midrst_err", 32'(bus.err), 32'd0);
    checkOutput("midrst_pending", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
`ifdef IMEM_LOADER_CSUM_EN
    runImage(1'b0, 1'b0, 1'b1, 8'h25, 1'b0);
`else
    runImage(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

`ifdef IMEM_LOADER_CSUM_EN
    $display("[TB] bad checksum");
    runImage(1'b0, 1'b0, 1'b1, 8'h26, 1'b1);
    $display("[TB] good checksum after bad one");
    runImage(1'b1, 1'b0, 1'b1, 8'h25, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("done_count", 32'(done_seen), 32'(exp_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
